audio_sample_sequencer: RTL and testbench

Per-sample controller between audio_codec and a time-shared moving-average datapath. It pops one stereo sample from the codec and inserts each channel into its own TAPS-deep delay line. A single shared accumulator then sums the left taps followed by the right taps, and the block pushes the stereo result back to the codec. It replaces free-running per-channel filters with an explicit read -> compute -> write handshake.

---
 rtl/audio_sample_sequencer.sv | 121 ++++++++++++
 tb/tb_audio_sample_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_sequencer.sv
// Per-sample stereo sequencer: pops a codec sample, feeds two TAPS-deep delay
// lines, runs a single shared accumulator over both channels, then pushes the result.
module audio_sample_sequencer #(
    parameter int WIDTH = 24,
    parameter int TAPS  = 8,
    parameter int SHIFT = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             read_ready,
    input  logic [WIDTH-1:0] readdata_left,
    input  logic [WIDTH-1:0] readdata_right,
    output logic             read,
    input  logic             write_ready,
    output logic             write,
    output logic [WIDTH-1:0] writedata_left,
    output logic [WIDTH-1:0] writedata_right,
    input  logic             bypass,
    output logic             busy,
    output logic [15:0]      frame_count
);

    typedef enum logic [2:0] {IDLE, READ, LOAD, ACC, WAIT_WR} state_t;

    state_t state, state_next;

    logic signed [WIDTH-1:0]       cur_l, cur_r;
    logic                          byp;
    logic signed [WIDTH-1:0]       line_l [TAPS];
    logic signed [WIDTH-1:0]       line_r [TAPS];
    logic [SHIFT-1:0]              wr_ptr;
    logic [SHIFT:0]                idx;
    logic signed [WIDTH+SHIFT-1:0] acc, acc_sum, tap_ext;
    logic signed [WIDTH-1:0]       tap, sum_l;
    logic                          last_left, last_right;

    // Top idx bit selects the right channel, since TAPS is a power of two.
    always_comb begin
        tap        = idx[SHIFT] ? line_r[idx[SHIFT-1:0]] : line_l[idx[SHIFT-1:0]];
        tap_ext    = {{SHIFT{tap[WIDTH-1]}}, tap};
        acc_sum    = acc + tap_ext;
        last_left  = (idx == (SHIFT+1)'(TAPS - 1));
        last_right = (idx == (SHIFT+1)'(2 * TAPS - 1));
    end

    assign read  = (state == READ);
    assign write = (state == WAIT_WR) && write_ready;
    assign busy  = (state != IDLE);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (read_ready) state_next = READ;
            READ:    state_next = LOAD;
            LOAD:    state_next = ACC;
            ACC:     if (last_right) state_next = WAIT_WR;
            WAIT_WR: if (write_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cur_l           <= '0;
            cur_r           <= '0;
            byp             <= 1'b0;
            wr_ptr          <= '0;
            idx             <= '0;
            acc             <= '0;
            sum_l           <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            frame_count     <= '0;
            for (int i = 0; i < TAPS; i++) begin
                line_l[i] <= '0;
                line_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (read_ready) begin
                        cur_l <= readdata_left;
                        cur_r <= readdata_right;
                        byp   <= bypass;
                    end
                end
                LOAD: begin
                    line_l[wr_ptr] <= cur_l >>> SHIFT;
                    line_r[wr_ptr] <= cur_r >>> SHIFT;
                    wr_ptr         <= wr_ptr + 1'b1;
                    acc            <= '0;
                    idx            <= '0;
                end
                ACC: begin
                    idx <= idx + 1'b1;
                    // Pre-scaled taps guarantee the sum fits in the low WIDTH bits.
                    if (last_left) begin
                        sum_l <= acc_sum[WIDTH-1:0];
                        acc   <= '0;
                    end else if (last_right) begin
                        acc             <= acc_sum;
                        writedata_left  <= byp ? cur_l : sum_l;
                        writedata_right <= byp ? cur_r : acc_sum[WIDTH-1:0];
                    end else begin
                        acc <= acc_sum;
                    end
                end
                WAIT_WR: begin
                    if (write_ready) frame_count <= frame_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed self-checking bench for audio_sample_sequencer (WIDTH=24, TAPS=8).
module tb_audio_sample_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_ready, write_ready, bypass;
    logic [23:0] readdata_left, readdata_right;
    logic        read, write, busy;
    logic [23:0] writedata_left, writedata_right;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_sample_sequencer #(.WIDTH(24), .TAPS(8), .SHIFT(3)) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .read_ready     (read_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .read           (read),
        .write_ready    (write_ready),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .bypass         (bypass),
        .busy           (busy),
        .frame_count    (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [23:0] l, input logic [23:0] r,
                                  input logic byp, input logic rr, input logic wr);
        readdata_left  = l;
        readdata_right = r;
        bypass         = byp;
        read_ready     = rr;
        write_ready    = wr;
    endtask

    // Advances on falling edges until write is seen; returns the edges waited.
    task automatic wait_write(output int cyc);
        cyc = 0;
        while (write !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) check("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        int stray;
        int changed;
        logic [23:0] hold_l, hold_r;
        logic [31:0] exp_l, exp_r;

        reset = 1'b1;
        apply_stimulus(24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        #3;
        check("rst_read", {31'd0, read}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wdl", writedata_left, 32'd0);
        check("rst_fc", frame_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // One full frame so the later reset has non-zero state to clear
        apply_stimulus(24'h080000, 24'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("pre_read", {31'd0, read}, 32'd1);
        read_ready = 1'b0;
        wait_write(cyc);
        check("pre_wdl", writedata_left, 32'h010000);
        @(negedge clk);
        check("pre_fc", frame_count, 32'd1);

        // Reset asserted mid-cycle while in ACC
        apply_stimulus(24'h080000, 24'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        read_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("acc_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_read", {31'd0, read}, 32'd0);
        check("midrst_write", {31'd0, write}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_wdl", writedata_left, 32'd0);
        check("midrst_wdr", writedata_right, 32'd0);
        check("midrst_fc", frame_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (write !== 1'b0) stray++;
        end
        check("no_stray_write", stray, 32'd0);
        apply_stimulus(24'h0, 24'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        read_ready = 1'b0;
        wait_write(cyc);
        check("zero_line_l", writedata_left, 32'd0);
        check("zero_line_r", writedata_right, 32'd0);
        @(negedge clk);

        // Ramp: left fills one tap per frame, back-to-back
        pulse_reset();
        apply_stimulus(24'h080000, 24'h0, 1'b0, 1'b1, 1'b1);
        for (int f = 1; f <= 10; f++) begin
            wait_write(cyc);
            if (f > 1) check("b2b_period", cyc, 32'd19);
            exp_l = (f < 8) ? f * 32'h010000 : 32'h080000;
            check("ramp_l", writedata_left, exp_l);
            check("ramp_r", writedata_right, 32'd0);
            if (f == 10) read_ready = 1'b0;
            @(negedge clk);
        end
        check("ramp_fc", frame_count, 32'd10);

        // Negative right input, left drains
        apply_stimulus(24'h0, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);
        for (int f = 1; f <= 8; f++) begin
            wait_write(cyc);
            exp_l = (8 - f) * 32'h010000;
            exp_r = (32'h01000000 - f) & 32'h00FFFFFF;
            check("neg_l", writedata_left, exp_l);
            check("neg_r", writedata_right, exp_r);
            if (f == 8) read_ready = 1'b0;
            @(negedge clk);
        end

        // Latency from read_ready sample to write
        apply_stimulus(24'h0, 24'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("lat_read", {31'd0, read}, 32'd1);
        check("lat_busy_rd", {31'd0, busy}, 32'd1);
        read_ready = 1'b0;
        wait_write(cyc);
        check("lat_cycles", cyc, 32'd18);
        check("lat_busy_wr", {31'd0, busy}, 32'd1);
        check("lat_l", writedata_left, 32'd0);
        check("lat_r", writedata_right, 32'h00FFFFF9);
        @(negedge clk);
        check("lat_write_drop", {31'd0, write}, 32'd0);
        check("lat_idle", {31'd0, busy}, 32'd0);

        // Stall in WAIT_WR with write_ready low
        apply_stimulus(24'h080000, 24'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("stall_read", {31'd0, read}, 32'd1);
        repeat (18) @(negedge clk);
        check("stall_busy", {31'd0, busy}, 32'd1);
        check("stall_write", {31'd0, write}, 32'd0);
        check("stall_l", writedata_left, 32'h010000);
        check("stall_r", writedata_right, 32'h00FFFFFA);
        hold_l = writedata_left;
        hold_r = writedata_right;
        stray = 0;
        changed = 0;
        repeat (50) begin
            @(negedge clk);
            if (read !== 1'b0 || write !== 1'b0) stray++;
            if (writedata_left !== hold_l || writedata_right !== hold_r) changed++;
        end
        check("stall_strobes", stray, 32'd0);
        check("stall_hold", changed, 32'd0);
        write_ready = 1'b1;
        #1;
        check("stall_release", {31'd0, write}, 32'd1);
        @(negedge clk);
        check("stall_one_write", {31'd0, write}, 32'd0);
        @(negedge clk);
        check("stall_next_read", {31'd0, read}, 32'd1);
        read_ready = 1'b0;
        wait_write(cyc);
        check("stall_next_lat", cyc, 32'd18);
        check("stall_next_l", writedata_left, 32'h020000);
        check("stall_next_r", writedata_right, 32'h00FFFFFB);
        @(negedge clk);
        check("total_fc", frame_count, 32'd21);

        // Bypass still feeds the delay line
        pulse_reset();
        apply_stimulus(24'h123456, 24'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("byp_read", {31'd0, read}, 32'd1);
        read_ready = 1'b0;
        wait_write(cyc);
        check("byp_lat", cyc, 32'd18);
        check("byp_l", writedata_left, 32'h123456);
        check("byp_r", writedata_right, 32'd0);
        @(negedge clk);
        apply_stimulus(24'h0, 24'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        read_ready = 1'b0;
        wait_write(cyc);
        check("post_byp_l", writedata_left, 32'h02468A);
        check("post_byp_r", writedata_right, 32'd0);
        @(negedge clk);
        check("byp_fc", frame_count, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
